// File: rtl/operand_pkg.sv
// Shared operand word type and default sizing for the operand FIFO and the downstream add-5 stage.
package operand_pkg;
  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH wrapping pointer; advances by one on each edge with inc=1.
// Latency: new value one edge after inc; no backpressure of its own.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == ($clog2(DEPTH))'(DEPTH - 1)) ? '0 : ptr + ($clog2(DEPTH))'(1);
    end
  end

endmodule

// File: rtl/operand_fifo.sv
// Operand FIFO feeding the add-5 stage: first word visible one cycle after its push.
// Backpressure: in_ready is registered (low when full); writes while full are dropped and flag overflow.
module operand_fifo
  import operand_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             in_ready_q;
  logic             overflow_q;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != '0) && out_ready;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // in_ready is held in a flop so it stays low through reset and never follows out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      in_ready_q <= (count_nxt != CW'(DEPTH));
      if (in_valid && !in_ready_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_operand_fifo.sv
// Bench for operand_fifo: vector table plus hand sequences, scored against a queue model.
module tb_operand_fifo;
  import operand_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  int          m_cnt = 0;
  logic        m_rdy = 1'b0;
  logic        m_ovf = 1'b0;

  word_t add_q;
  logic  add_vld;

  always #5 clk = ~clk;

  operand_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  // Downstream add-5 stage consuming the FIFO output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q   <= '0;
      add_vld <= 1'b0;
    end else begin
      add_vld <= out_valid && out_ready;
      if (out_valid && out_ready) add_q <= out_data + word_t'(5);
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    int          exp_cnt;
    logic        exp_rdy;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive, check against the model before the edge, then advance the model.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
    logic do_push;
    logic do_pop;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_cnt != 0});
    chk("count", {29'b0, count}, 32'(m_cnt));
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (m_cnt != 0 && sb.size() > 0) chk("out_data", out_data, sb[0]);
    do_push = iv && m_rdy;
    do_pop = (m_cnt != 0) && ordy;
    if (iv && !m_rdy) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back(d);
    m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    m_rdy = (m_cnt != DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 32'd1, 1'b0, 1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'd2, 1'b0, 2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'd3, 1'b0, 3, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'd4, 1'b0, 4, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'd5, 1'b0, 4, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'd0, 1'b1, 3, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'd0, 1'b1, 2, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'd0, 1'b1, 1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'd0, 1'b1, 0, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'd0, 1'b1, 0, 1'b1, 1'b1};

    // Fill past full, then drain: only 1..4 come out.
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), {29'b0, count}, 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
      if (i == 2) chk("vec2_out_data", out_data, 32'd1);
    end

    // Streaming 0..9 with the consumer always ready: count stays at 1.
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i), 1'b1);
      chk("stream_count", {29'b0, count}, 32'd1);
      chk("stream_data", out_data, 32'(i));
    end
    step(1'b0, 32'd0, 1'b1);
    chk("stream_drained", {29'b0, count}, 32'd0);

    // Full with both sides active: pop happens, push is refused, then accepted next cycle.
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(i), 1'b0);
    step(1'b1, 32'h50, 1'b1);
    chk("full_pop_count", {29'b0, count}, 32'd3);
    chk("full_pop_ready", {31'b0, in_ready}, 32'd1);
    step(1'b1, 32'h50, 1'b0);
    chk("full_next_push", {29'b0, count}, 32'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
    chk("full_drained", {29'b0, count}, 32'd0);

    // Reset in the middle of a cycle discards stored words.
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h70 + 32'(i), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_count", {29'b0, count}, 32'd0);
    sb.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hA, 1'b0);
    chk("midrst_first", out_data, 32'hA);
    step(1'b0, 32'd0, 1'b1);

    // Chained add-5 stage wraps at 32 bits.
    do_reset();
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'hFFFF_FFFD, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("add5_valid", {31'b0, add_vld}, 32'd1);
    chk("add5_result", add_q, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fifo.md
OPERAND_FIFO -- requirements
Module: operand_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: bit width of each operand word.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: operand word from the producer.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: operand word to the downstream add-5 stage (its x input).
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage takes out_data this cycle.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of stored words.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is attempted while full.

Function
REQ-013 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; in_data is written at the write pointer, and the pointer advances modulo DEPTH.
REQ-014 A pop SHALL occur on a rising edge where out_valid and out_ready are both 1; the read pointer advances modulo DEPTH.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL depend only on registered state, never combinationally on out_ready.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL be the word at the read pointer, and its value is don't-care while out_valid is 0.
REQ-017 Latency: a word pushed at edge N SHALL be visible on out_data with out_valid=1 after edge N (first-word latency 1 cycle).
REQ-018 On an edge with both a push and a pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 When full with out_ready=1, the pop SHALL occur and in_ready SHALL rise in the following cycle; no push is accepted in the full cycle.
REQ-020 When empty with in_valid=1, the push SHALL occur; no pop occurs in that cycle regardless of out_ready.
REQ-021 Pointer wrap SHALL be seamless: word order is strictly FIFO across DEPTH boundaries, with no lost or duplicated words.
REQ-022 overflow SHALL go to 1 on any edge with in_valid=1 and in_ready=0, and SHALL hold 1 until reset; the rejected word SHALL NOT be stored.
REQ-023 count SHALL never exceed DEPTH and never wrap below 0 (candidate formal assertions).
REQ-024 Data SHALL pass through unmodified; arithmetic is done only by the downstream add-5 stage.

Reset
REQ-025 While rst_n=0, asynchronously: pointers=0, count=0, out_valid=0, in_ready=0, overflow=0.
REQ-026 in_ready SHALL become 1 on the first rising edge after rst_n deasserts.
REQ-027 Storage contents SHALL NOT be reset; they are unobservable while count=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; after release, the first popped word is the first word pushed after release.

Structure
REQ-029 Package operand_pkg SHALL hold WORD_W=32, FIFO_DEPTH=4, and typedef word_t (logic [WORD_W-1:0]); the downstream add stage shares word_t.
REQ-030 One sub-module, fifo_ptr (wrapping modulo-DEPTH pointer with an increment enable, asynchronous active-low reset), SHALL be instantiated twice, once for read and once for write.
REQ-031 Storage SHALL be a register array indexed by the pointers; no RAM macro.

Verification
REQ-032 Reset then push 1,2,3 on consecutive cycles with out_ready=0 -> count=3, out_data=1, in_ready=1, overflow=0.
REQ-033 Push 5 words into DEPTH=4 with out_ready=0 -> count=4, in_ready=0 after the 4th word, overflow=1 after the 5th; pops then yield 1,2,3,4 only.
REQ-034 Continuous push 0..9 with out_ready=1 -> outputs 0..9 in order, each 1 cycle after its push, count holds at 1, pointers wrap twice.
REQ-035 Full FIFO, out_ready=1, in_valid=1 -> one pop, no push that cycle, push accepted the next cycle, order preserved.
REQ-036 count=3, assert rst_n=0 mid-cycle -> out_valid=0 and count=0 immediately; after release push 0xA -> first output is 0xA.
REQ-037 Chained to the add-5 stage, push 0xFFFFFFFD -> downstream result 0x00000002 (32-bit wrap) two cycles later.
